// File: rtl/paquete_micro.sv
// paquete_micro: shared state codes, instruction field positions and data width
package paquete_micro;
   localparam int ANCHO_DATO = 8;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int RX_MSB  = 4;
   localparam int RX_LSB  = 3;
   localparam int RY_MSB  = 2;
   localparam int RY_LSB  = 1;
   localparam int INM_BIT = 0;
   typedef enum logic [2:0] {
      BUSCA       = 3'd0,
      DECODIFICA  = 3'd1,
      EJECUTA     = 3'd2,
      ESCRIBE     = 3'd3,
      INM_LEE     = 3'd4,
      INM_CAPTURA = 3'd5
   } estado_t;
endpackage

// File: rtl/banco_registros.sv
// banco_registros: 4x8 register file, two async read ports, one sync write port
module banco_registros
   import paquete_micro::*;
(
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_We,
   input  logic [1:0]            i_Dir_w,
   input  logic [ANCHO_DATO-1:0] i_Dato_w,
   input  logic [1:0]            i_Dir_a,
   input  logic [1:0]            i_Dir_b,
   output logic [ANCHO_DATO-1:0] o_Dato_a,
   output logic [ANCHO_DATO-1:0] o_Dato_b
);
   logic [ANCHO_DATO-1:0] r_banco [4];
   assign o_Dato_a = r_banco[i_Dir_a];
   assign o_Dato_b = r_banco[i_Dir_b];
   // registers clear asynchronously, otherwise take the write port on the edge
   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) r_banco <= '{default: '0};
      else if (i_We) r_banco[i_Dir_w] <= i_Dato_w;
endmodule

// File: rtl/unidad_control.sv
// unidad_control: fetch/decode/execute sequencer driving program memory, ALU and register bank
module unidad_control
   import paquete_micro::*;
#(
   parameter int ANCHO_DIR = 8
)(
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Ejecutar,
   output logic [ANCHO_DIR-1:0]  o_Dir,
   output logic                  o_Leer,
   input  logic [ANCHO_DATO-1:0] i_Dato,
   output logic [2:0]            o_Inst_decodificada,
   output logic [ANCHO_DATO-1:0] o_RX,
   output logic [ANCHO_DATO-1:0] o_RY,
   output logic                  o_Hab,
   input  logic [ANCHO_DATO-1:0] i_Resultado,
   input  logic [2:0]            i_Bandera,
   output logic [2:0]            o_Banderas,
   output logic [2:0]            o_Estado
);
   estado_t               estado, estado_sig;
   logic [ANCHO_DIR-1:0]  pc;
   logic [ANCHO_DATO-1:0] ir;
   logic                  we;
   assign o_Dir               = pc;
   assign o_Estado            = estado;
   assign o_Inst_decodificada = ir[OP_MSB:OP_LSB];
   banco_registros u_banco (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_We     (we),
      .i_Dir_w  (ir[RX_MSB:RX_LSB]),
      .i_Dato_w (ir[INM_BIT] ? i_Dato : i_Resultado),
      .i_Dir_a  (ir[RX_MSB:RX_LSB]),
      .i_Dir_b  (ir[RY_MSB:RY_LSB]),
      .o_Dato_a (o_RX),
      .o_Dato_b (o_RY)
   );
   // next state and strobes; the read strobe is gated by reset since BUSCA is also the reset state
   always_comb begin
      estado_sig = BUSCA;
      o_Leer     = 1'b0;
      o_Hab      = 1'b0;
      we         = 1'b0;
      case (estado)
         BUSCA: begin
            o_Leer     = i_Rst_n && i_Ejecutar;
            estado_sig = i_Ejecutar ? DECODIFICA : BUSCA;
         end
         DECODIFICA:  estado_sig = i_Dato[INM_BIT] ? INM_LEE : EJECUTA;
         EJECUTA: begin
            o_Hab      = 1'b1;
            estado_sig = ESCRIBE;
         end
         ESCRIBE:     we = 1'b1;
         INM_LEE: begin
            o_Leer     = 1'b1;
            estado_sig = INM_CAPTURA;
         end
         INM_CAPTURA: we = 1'b1;
         default:     estado_sig = BUSCA;
      endcase
   end
   // state, PC, IR and flag registers; PC steps past the opcode and past the immediate
   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) begin
         estado     <= BUSCA;
         pc         <= '0;
         ir         <= '0;
         o_Banderas <= '0;
      end else begin
         estado <= estado_sig;
         if (estado == DECODIFICA) ir <= i_Dato;
         if (estado == DECODIFICA || estado == INM_CAPTURA) pc <= pc + ANCHO_DIR'(1);
         if (estado == ESCRIBE) o_Banderas <= i_Bandera;
      end
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: directed vectors and corner sequences for unidad_control
module tb_unidad_control;
   logic       i_Clk, i_Rst_n, i_Ejecutar, o_Leer, o_Hab;
   logic [7:0] o_Dir, i_Dato, o_RX, o_RY, i_Resultado;
   logic [2:0] o_Inst_decodificada, i_Bandera, o_Banderas, o_Estado;
   logic [7:0] mem [256];
   logic [2:0] bandera_modelo;
   int         pasadas, total;

   unidad_control #(.ANCHO_DIR(8)) dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Ejecutar(i_Ejecutar), .o_Dir(o_Dir), .o_Leer(o_Leer),
      .i_Dato(i_Dato), .o_Inst_decodificada(o_Inst_decodificada), .o_RX(o_RX), .o_RY(o_RY),
      .o_Hab(o_Hab), .i_Resultado(i_Resultado), .i_Bandera(i_Bandera), .o_Banderas(o_Banderas),
      .o_Estado(o_Estado)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // synchronous program memory: data appears the cycle after the strobe
   always @(posedge i_Clk) if (o_Leer) i_Dato <= mem[o_Dir];

   function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // ALU model
   always_comb begin
      i_Resultado = alu(o_Inst_decodificada, o_RX, o_RY);
      i_Bandera   = bandera_modelo;
   end

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, act, exp);
      else pasadas++;
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(posedge i_Clk);
      #1;
   endtask

   task automatic correr(input int n_instr);
      i_Ejecutar = 1'b1;
      ciclos(4 * n_instr);
      i_Ejecutar = 1'b0;
   endtask

   task automatic reiniciar();
      i_Rst_n = 1'b0;
      ciclos(1);
      i_Rst_n = 1'b1;
   endtask

   task automatic ponmem(input logic [7:0] a, input logic [7:0] d);
      mem[a] = d;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [1:0] rx, ry;
      logic [7:0] a, b, esperado;
      logic [2:0] fl;
   } vector_t;

   vector_t    tabla [8];
   logic [7:0] pc_m;
   int         n_hab;

   initial begin
      pasadas = 0; total = 0; bandera_modelo = 3'b000;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      i_Dato = 8'h00;
      tabla[0] = '{3'd0, 2'd1, 2'd2, 8'h7F, 8'h01, 8'h80, 3'b010};
      tabla[1] = '{3'd0, 2'd3, 2'd0, 8'hFF, 8'h02, 8'h01, 3'b001};
      tabla[2] = '{3'd1, 2'd2, 2'd1, 8'h10, 8'h11, 8'hFF, 3'b110};
      tabla[3] = '{3'd2, 2'd0, 2'd3, 8'hF0, 8'h3C, 8'h30, 3'b100};
      tabla[4] = '{3'd3, 2'd1, 2'd0, 8'h0F, 8'hA0, 8'hAF, 3'b011};
      tabla[5] = '{3'd4, 2'd2, 2'd3, 8'hFF, 8'h5A, 8'hA5, 3'b111};
      tabla[6] = '{3'd0, 2'd1, 2'd1, 8'h21, 8'h21, 8'h42, 3'b000};
      tabla[7] = '{3'd7, 2'd3, 2'd2, 8'h12, 8'h34, 8'hED, 3'b101};

      // reset state, with run enable already high
      i_Ejecutar = 1'b1; i_Rst_n = 1'b0;
      #12;
      chk("rst_dir", o_Dir, 8'h00);
      chk("rst_hab", o_Hab, 1'b0);
      chk("rst_leer", o_Leer, 1'b0);
      chk("rst_banderas", o_Banderas, 3'b000);
      chk("rst_estado", o_Estado, 3'd0);

      // LDI R0,#0F ; LDI R1,#01 ; ADD R0,R1
      mem[0] = 8'h01; mem[1] = 8'h0F; mem[2] = 8'h09; mem[3] = 8'h01; mem[4] = 8'h02;
      @(posedge i_Clk); #1;
      i_Rst_n = 1'b1;
      ciclos(4);
      chk("ldi0_r0", o_RX, 8'h0F);
      chk("ldi0_dir", o_Dir, 8'h02);
      chk("ldi0_estado", o_Estado, 3'd0);
      ciclos(4);
      chk("ldi1_r1", o_RX, 8'h01);
      ciclos(2);
      chk("eje_estado", o_Estado, 3'd2);
      chk("eje_hab", o_Hab, 1'b1);
      chk("eje_inst", o_Inst_decodificada, 3'b000);
      chk("eje_rx", o_RX, 8'h0F);
      chk("eje_ry", o_RY, 8'h01);
      chk("eje_leer", o_Leer, 1'b0);
      ciclos(1);
      chk("esc_estado", o_Estado, 3'd3);
      chk("esc_hab", o_Hab, 1'b0);
      ciclos(1);
      i_Ejecutar = 1'b0;
      chk("add_r0", o_RX, 8'h10);
      chk("add_banderas", o_Banderas, 3'b000);
      chk("add_estado", o_Estado, 3'd0);
      chk("add_dir", o_Dir, 8'h05);

      // drop run enable during DECODIFICA of 0x02
      reiniciar();
      mem[0] = 8'h02;
      i_Ejecutar = 1'b1;
      ciclos(1);
      chk("drop_deco", o_Estado, 3'd1);
      i_Ejecutar = 1'b0;
      n_hab = 0;
      for (int i = 0; i < 6; i++) begin
         if (o_Hab) n_hab++;
         ciclos(1);
      end
      chk("drop_hab_pulsos", n_hab, 1);
      chk("drop_leer", o_Leer, 1'b0);
      chk("drop_dir", o_Dir, 8'h01);
      chk("drop_estado", o_Estado, 3'd0);

      // table: LDI rx,#a ; LDI ry,#b ; op rx,ry
      pc_m = 8'h01;
      for (int i = 0; i < 8; i++) begin
         ponmem(pc_m,        {3'b000, tabla[i].rx, 2'b00, 1'b1});
         ponmem(pc_m + 8'd1, tabla[i].a);
         ponmem(pc_m + 8'd2, {3'b000, tabla[i].ry, 2'b00, 1'b1});
         ponmem(pc_m + 8'd3, tabla[i].b);
         ponmem(pc_m + 8'd4, {tabla[i].op, tabla[i].rx, tabla[i].ry, 1'b0});
         bandera_modelo = tabla[i].fl;
         correr(3);
         chk($sformatf("vec%0d_res", i), o_RX, tabla[i].esperado);
         chk($sformatf("vec%0d_flags", i), o_Banderas, tabla[i].fl);
         chk($sformatf("vec%0d_dir", i), o_Dir, pc_m + 8'd5);
         pc_m = pc_m + 8'd5;
      end

      // PC wrap between an LDI opcode at 0xFF and its immediate at 0x00
      reiniciar();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h5A; mem[255] = 8'h01;
      bandera_modelo = 3'b000;
      correr(255);
      chk("wrap_pre_dir", o_Dir, 8'hFF);
      correr(1);
      chk("wrap_r0", o_RX, 8'h5A);
      chk("wrap_dir", o_Dir, 8'h01);

      // flags captured by an ALU op, untouched by the following LDI
      mem[1] = 8'h62; bandera_modelo = 3'b101;
      correr(1);
      chk("flag_alu", o_Banderas, 3'b101);
      chk("flag_res", o_RX, 8'h5A);
      mem[2] = 8'h0B; mem[3] = 8'h33; bandera_modelo = 3'b010;
      correr(1);
      chk("flag_ldi", o_Banderas, 3'b101);
      chk("flag_ldi_r1", o_RX, 8'h33);
      chk("flag_ldi_dir", o_Dir, 8'h04);

      // asynchronous reset during EJECUTA
      mem[4] = 8'h02;
      i_Ejecutar = 1'b1;
      ciclos(2);
      chk("arst_pre_hab", o_Hab, 1'b1);
      chk("arst_pre_estado", o_Estado, 3'd2);
      i_Rst_n = 1'b0;
      #1;
      chk("arst_hab", o_Hab, 1'b0);
      chk("arst_leer", o_Leer, 1'b0);
      chk("arst_estado", o_Estado, 3'd0);
      chk("arst_dir", o_Dir, 8'h00);
      chk("arst_banderas", o_Banderas, 3'b000);
      chk("arst_r0", o_RX, 8'h00);
      chk("arst_r1", dut.u_banco.r_banco[1], 8'h00);
      @(posedge i_Clk); #1;
      i_Rst_n = 1'b1;
      #1;
      chk("arst_fetch_leer", o_Leer, 1'b1);
      chk("arst_fetch_dir", o_Dir, 8'h00);
      ciclos(1);
      chk("arst_fetch_deco", o_Estado, 3'd1);
      i_Ejecutar = 1'b0;

      $display("%0d/%0d checks passed", pasadas, total);
      $finish;
   end
endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 Parameter ANCHO_DIR, default 8, program-address width; PC wraps modulo 2^ANCHO_DIR.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports named i_Clk and i_Rst_n.
REQ-003 i_Clk  in  1  system clock, all state updates on rising edge.
REQ-004 i_Rst_n  in  1  asynchronous active-low reset.
REQ-005 i_Ejecutar  in  1  run enable; sampled only in state BUSCA.
REQ-006 o_Dir  out  ANCHO_DIR  program-memory address (current PC).
REQ-007 o_Leer  out  1  program-memory read strobe; i_Dato is valid the cycle after o_Leer=1.
REQ-008 i_Dato  in  8  program-memory read data.
REQ-009 o_Inst_decodificada  out  3  ALU opcode, IR[7:5].
REQ-010 o_RX  out  8  bank register selected by IR[4:3].
REQ-011 o_RY  out  8  bank register selected by IR[2:1].
REQ-012 o_Hab  out  1  ALU enable, one-cycle pulse per ALU instruction.
REQ-013 i_Resultado  in  8  ALU result.
REQ-014 i_Bandera  in  3  ALU flags.
REQ-015 o_Banderas  out  3  registered flags from the last ALU instruction.
REQ-016 o_Estado  out  3  current FSM state encoding.

Function
REQ-017 Instruction byte SHALL be {op[2:0], rx[1:0], ry[1:0], inm}; inm=1 means LDI rx,#byte (op, ry ignored), inm=0 means ALU op rx,ry -> rx.
REQ-018 FSM states: BUSCA=0, DECODIFICA=1, EJECUTA=2, ESCRIBE=3, INM_LEE=4, INM_CAPTURA=5; codes 6,7 SHALL go to BUSCA.
REQ-019 BUSCA: if i_Ejecutar=1 then o_Leer=1, o_Dir=PC, next DECODIFICA; else o_Leer=0, stay.
REQ-020 DECODIFICA: IR<=i_Dato, PC<=PC+1; next INM_LEE if i_Dato[0]=1, else EJECUTA.
REQ-021 EJECUTA: o_Hab=1; next ESCRIBE.
REQ-022 ESCRIBE: bank[rx]<=i_Resultado, o_Banderas<=i_Bandera; next BUSCA.
REQ-023 INM_LEE: o_Leer=1, o_Dir=PC; next INM_CAPTURA.
REQ-024 INM_CAPTURA: bank[rx]<=i_Dato, PC<=PC+1, o_Banderas unchanged; next BUSCA.
REQ-025 Latency: every instruction (ALU or LDI) SHALL take exactly 4 cycles BUSCA-to-BUSCA.
REQ-026 o_Inst_decodificada, o_RX, o_RY SHALL be combinational from IR and bank, stable through EJECUTA and ESCRIBE.
REQ-027 o_Hab and o_Leer SHALL be low in every state not listed above.
REQ-028 Deasserting i_Ejecutar mid-instruction SHALL NOT abort it; block parks in BUSCA afterwards with o_Dir holding PC.
REQ-029 PC SHALL wrap 0xFF->0x00 without error, including between an LDI opcode and its immediate.
REQ-030 rx==ry is legal; the write in ESCRIBE uses the value read in EJECUTA.

Reset
REQ-031 While i_Rst_n=0: state=BUSCA, PC=0, IR=0, bank registers=0, o_Banderas=0, o_Hab=0, o_Leer=0, asynchronously, including mid-instruction.
REQ-032 The first fetch after reset release SHALL be from address 0 on the first edge with i_Ejecutar=1.

Structure
REQ-033 State codes, opcode field positions and data width (8) SHALL live in shared package paquete_micro.
REQ-034 The 4x8 register file SHALL be sub-module banco_registros (two async read ports, one sync write port, async reset).

Verification
REQ-035 Reset: hold i_Rst_n=0 -> o_Dir=0x00, o_Hab=0, o_Leer=0, o_Banderas=3'b000, o_Estado=0.
REQ-036 Memory {0x01,0x0F,0x09,0x01,0x02}, i_Ejecutar=1 -> R0=0x0F after cycle 4, R1=0x01 after cycle 8; cycle 10: o_Inst_decodificada=000, o_RX=0x0F, o_RY=0x01, o_Hab=1; model returns 0x10/3'b000 -> R0=0x10.
REQ-037 Drop i_Ejecutar in DECODIFICA of 0x02 -> instruction completes with one o_Hab pulse, then o_Leer=0, o_Dir=0x01 held.
REQ-038 LDI 0x01 at 0xFF, 0x5A at 0x00 -> R0=0x5A, next fetch o_Dir=0x01.
REQ-039 Pulse i_Rst_n=0 during EJECUTA -> o_Hab falls same cycle, bank cleared, next fetch o_Dir=0x00.
REQ-040 Model flags 3'b101 on op 0x62 -> o_Banderas=3'b101 after ESCRIBE; following LDI leaves it unchanged.
